seg_display_driver: RTL and testbench

- Downstream stage of the 28-bit seven-segment PIO.
- Consumes the PIO's out_port word (4 digits x 7 segments) and drives the four board HEX displays, which are active-low.
- Adds global brightness PWM, per-digit blink and a blank control.
- Latches new pattern/brightness/blink settings only at PWM period boundaries, so a CPU update never produces a partial frame.

---
 rtl/seg_display_if.sv | 36 +++
 rtl/seg_display_driver.sv | 104 ++++++++++
 tb/tb_seg_display_driver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_if
// Description : Bundle between the seven-segment PIO side and the HEX display
//               driver. It carries the pattern and brightness settings toward
//               the driver, and carries the segment drives and period strobe
//               back out.
//               master : produces seg_in/brightness/blink_mask/blank and
//                        observes hex0..hex3/period_strobe
//               slave  : the display driver
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_display_if #(
    parameter int PWM_BITS = 8
);
    logic [27:0]         seg_in;         // 1 = segment lit, digit i at [7i+6:7i]
    logic [PWM_BITS-1:0] brightness;     // PWM duty value
    logic [3:0]          blink_mask;     // bit i = 1 blinks digit i
    logic                blank;          // 1 = all segments off, acts next cycle
    logic [6:0]          hex0;           // active-low segment drives, digit 0
    logic [6:0]          hex1;
    logic [6:0]          hex2;
    logic [6:0]          hex3;
    logic                period_strobe;  // high on the last cycle of each PWM period

    modport master (
        output seg_in, brightness, blink_mask, blank,
        input  hex0, hex1, hex2, hex3, period_strobe
    );

    modport slave (
        input  seg_in, brightness, blink_mask, blank,
        output hex0, hex1, hex2, hex3, period_strobe
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_driver
// Description : Drives four active-low HEX displays from the 28-bit segment
//               word. It adds global brightness PWM, per-digit blink and a
//               blank control. Pattern, brightness and blink mask are
//               captured into shadow registers only on the last cycle of a
//               PWM period, so a CPU update never shows a partial frame.
// Ports       : clk    - system clock
//               reset  - asynchronous, active-high reset
//               bus    - seg_display_if.slave (settings in, segment drives
//                        and period strobe out)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_driver #(
    parameter int PWM_BITS  = 8,
    parameter int BLINK_DIV = 12500000
) (
    input  wire logic    clk,
    input  wire logic    reset,
    seg_display_if.slave bus
);

    localparam int                  c_BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [PWM_BITS-1:0] c_PWM_MAX    = '1;
    localparam logic [PWM_BITS-1:0] c_PWM_PRE    = c_PWM_MAX - 1'b1;
    localparam logic [6:0]          c_HEX_OFF    = 7'h7F;

    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;   // 1 = blinking digits visible
    logic [27:0]          r_seg_sh;
    logic [PWM_BITS-1:0]  r_bright_sh;
    logic [3:0]           r_mask_sh;
    logic                 r_strobe;
    logic [3:0][6:0]      r_hex;

    logic                 w_pwm_last;
    logic                 w_pwm_on;
    logic [3:0]           w_show;
    logic [3:0][6:0]      w_hex_nxt;

    assign w_pwm_last = (r_pwm_cnt == c_PWM_MAX);

    // All-ones brightness must stay lit on the final count too, which the
    // plain compare alone would miss.
    assign w_pwm_on = (r_pwm_cnt < r_bright_sh) || (r_bright_sh == c_PWM_MAX);

    for (genvar i = 0; i < 4; i++) begin : g_digit
        assign w_show[i]    = ~(r_mask_sh[i] & ~r_blink_phase);
        assign w_hex_nxt[i] = ~(r_seg_sh[7*i +: 7] & {7{w_pwm_on & w_show[i] & ~bus.blank}});
    end

    // Counters, shadow capture and strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_seg_sh      <= '0;
            r_bright_sh   <= '0;
            r_mask_sh     <= '0;
            r_strobe      <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;

            // Registered one cycle early so the strobe is high during the
            // very cycle in which the shadow registers capture.
            r_strobe <= (r_pwm_cnt == c_PWM_PRE);

            if (w_pwm_last) begin
                r_seg_sh    <= bus.seg_in;
                r_bright_sh <= bus.brightness;
                r_mask_sh   <= bus.blink_mask;
            end

            // Blink timebase runs free of the PWM period and shadow loads.
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Registered output stage: no combinational path from inputs to pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex <= {4{c_HEX_OFF}};
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

    assign bus.hex0          = r_hex[0];
    assign bus.hex1          = r_hex[1];
    assign bus.hex2          = r_hex[2];
    assign bus.hex3          = r_hex[3];
    assign bus.period_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_driver
// Description : Scoreboard bench for seg_display_driver (PWM_BITS=4,
//               BLINK_DIV=8). The stimulus process drives directed vectors
//               and queues the hand-derived output expected in each cycle;
//               a monitor on the falling edge pops and compares.
//               Cycle k counts rising edges since the last reset release.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg_display_driver;

    localparam int PWM_BITS  = 4;
    localparam int BLINK_DIV = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   base   = 0;
    int   checks = 0;
    int   errors = 0;
    logic drain_req = 1'b0;
    logic drained   = 1'b0;

    seg_display_if #(.PWM_BITS(PWM_BITS)) bus ();

    seg_display_driver #(
        .PWM_BITS (PWM_BITS),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         at;
        int         k;
        logic [6:0] h0;
        logic [6:0] h1;
        logic [6:0] h2;
        logic [6:0] h3;
        logic       st;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];

    task automatic push(input int k, input string nm, input logic [6:0] a, input logic [6:0] b,
                        input logic [6:0] c, input logic [6:0] d, input logic st);
        exp_t e;
        e.at = base + k;
        e.k  = k;
        e.h0 = a;
        e.h1 = b;
        e.h2 = c;
        e.h3 = d;
        e.st = st;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    // Strobe is high in every cycle whose counter value is 15.
    task automatic push_std(input int k, input string nm, input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d);
        push(k, nm, a, b, c, d, ((k % 16) == 15));
    endtask

    task automatic wait_k(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        exp_t  e;
        string nm;
        while (q_exp.size() > 0 && q_exp[0].at <= cyc) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            checks++;
            if (e.at < cyc) begin
                errors++;
                $display("FAIL %s k=%0d: expectation skipped, now cycle %0d", nm, e.k, cyc);
            end else if ({bus.hex0, bus.hex1, bus.hex2, bus.hex3, bus.period_strobe} !==
                         {e.h0, e.h1, e.h2, e.h3, e.st}) begin
                errors++;
                $display("FAIL %s k=%0d: got hex0..3=%h %h %h %h strobe=%b, expected %h %h %h %h strobe=%b",
                         nm, e.k, bus.hex0, bus.hex1, bus.hex2, bus.hex3, bus.period_strobe,
                         e.h0, e.h1, e.h2, e.h3, e.st);
            end
        end
        if (drain_req && !drained) begin
            checks++;
            if (q_exp.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d expectations left, expected 0", q_exp.size());
            end
            drained = 1'b1;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [6:0] v;
        bus.seg_in     = 28'h0000006;
        bus.brightness = 4'hF;
        bus.blink_mask = 4'b0000;
        bus.blank      = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;

        // Digit 0 "1" at full brightness; dark until the first load propagates.
        for (int k = 0; k <= 32; k++)
            push_std(k, "load_digit0", (k >= 17) ? 7'h79 : 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // Duty 4/16 with all segments, then brightness 0.
        wait_k(33);
        bus.seg_in     = 28'hFFFFFFF;
        bus.brightness = 4'd4;
        for (int k = 33; k <= 96; k++) begin
            if (k <= 48)
                push_std(k, "duty_old", 7'h79, 7'h7F, 7'h7F, 7'h7F);
            else if (k <= 80) begin
                v = ((k % 16) >= 1 && (k % 16) <= 4) ? 7'h00 : 7'h7F;
                push_std(k, "duty4", v, v, v, v);
            end else
                push_std(k, "duty0", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        end
        wait_k(65);
        bus.brightness = 4'd0;

        // Full on, then a mid-period glitch that is reverted, then a real update.
        wait_k(97);
        bus.seg_in     = 28'hFFFFFFF;
        bus.brightness = 4'hF;
        for (int k = 97; k <= 160; k++) begin
            if (k <= 112)
                push_std(k, "full_wait", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
            else if (k <= 144)
                push_std(k, "glitch_hold", 7'h00, 7'h00, 7'h00, 7'h00);
            else
                push_std(k, "update", 7'h40, 7'h79, 7'h24, 7'h30);
        end
        wait_k(119);
        bus.seg_in = 28'h0000006;
        wait_k(122);
        bus.seg_in = 28'hFFFFFFF;
        wait_k(135);
        bus.seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};

        // Blink digit 1; blink phase flips every 8 cycles from release.
        wait_k(161);
        bus.seg_in     = 28'hFFFFFFF;
        bus.blink_mask = 4'b0010;
        for (int k = 161; k <= 224; k++) begin
            if (k <= 176)
                push_std(k, "blink_old", 7'h40, 7'h79, 7'h24, 7'h30);
            else begin
                v = ((((k - 1) / 8) % 2) == 0) ? 7'h00 : 7'h7F;
                push_std(k, "blink", 7'h00, v, 7'h00, 7'h00);
            end
        end

        // Stop blinking, then a 3-cycle blank pulse.
        wait_k(209);
        bus.blink_mask = 4'b0000;
        for (int k = 225; k <= 249; k++) begin
            v = (k >= 231 && k <= 233) ? 7'h7F : 7'h00;
            push_std(k, "blank", v, v, v, v);
        end
        wait_k(230);
        bus.blank = 1'b1;
        wait_k(233);
        bus.blank = 1'b0;

        // Asynchronous reset mid-run.
        for (int k = 250; k <= 252; k++)
            push(k, "reset_async", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
        wait_k(250);
        reset = 1'b1;
        wait_k(253);
        reset = 1'b0;
        base  = cyc;
        for (int k = 0; k <= 24; k++) begin
            v = (k >= 17) ? 7'h00 : 7'h7F;
            push_std(k, "after_reset", v, v, v, v);
        end
        wait_k(26);

        drain_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!drained)
            $display("FAIL drain: got no drain check, expected one");
        $display("Result: errors=%0d of %0d checks", errors + (drained ? 0 : 1), checks);
        $finish;
    end

endmodule
`default_nettype wire
